// File: rtl/alu_issue.sv
// alu_issue: decodes opcode/funct into the ALU operation code, selects the
// second operand, and holds decoded entries in a two-deep head/skid buffer
// in front of the EX-stage ALU. Backpressure toward ID comes only from
// registered occupancy.
module alu_issue (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [5:0]  op_i,
  input  logic [5:0]  funct_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  input  logic [15:0] imm_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] data1_o,
  output logic [31:0] data2_o,
  output logic [2:0]  ALUCtrl_o,
  output logic        illegal_o,
  output logic [15:0] issue_cnt_o
);

  localparam logic [2:0] CTRL_NONE = 3'd0;
  localparam logic [2:0] CTRL_ADD  = 3'd1;
  localparam logic [2:0] CTRL_SUB  = 3'd2;
  localparam logic [2:0] CTRL_AND  = 3'd3;
  localparam logic [2:0] CTRL_OR   = 3'd4;
  localparam logic [2:0] CTRL_MUL  = 3'd5;

  // occupancy: 0 = empty, 1 = head only, 2 = head + skid
  logic [1:0]  count;

  logic [31:0] skid_data1;
  logic [31:0] skid_data2;
  logic [2:0]  skid_ctrl;
  logic        skid_illegal;

  logic [31:0] dec_data2;
  logic [2:0]  dec_ctrl;
  logic        dec_illegal;

  logic        push;
  logic        pop;

  assign ready_o = (count != 2'd2);
  assign valid_o = (count != 2'd0);
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ready_i;

  // Decode the incoming instruction into operation code and second operand.
  always_comb begin
    dec_ctrl    = CTRL_NONE;
    dec_data2   = rt_data_i;
    dec_illegal = 1'b0;
    case (op_i)
      6'b000000: begin
        case (funct_i)
          6'b100000: dec_ctrl = CTRL_ADD;
          6'b100010: dec_ctrl = CTRL_SUB;
          6'b100100: dec_ctrl = CTRL_AND;
          6'b100101: dec_ctrl = CTRL_OR;
          6'b011000: dec_ctrl = CTRL_MUL;
          default:   dec_illegal = 1'b1;
        endcase
      end
      6'b001000, 6'b100011, 6'b101011: begin
        dec_ctrl  = CTRL_ADD;
        dec_data2 = {{16{imm_i[15]}}, imm_i};
      end
      6'b000100: dec_ctrl = CTRL_SUB;
      default:   dec_illegal = 1'b1;
    endcase
  end

  // Occupancy tracking; flush wins over any push in the same cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count <= 2'd0;
    end else if (flush_i) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Head register: loads a new entry when it becomes the oldest one,
  // or takes the skid entry when the head leaves with two buffered.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data1_o   <= 32'd0;
      data2_o   <= 32'd0;
      ALUCtrl_o <= CTRL_NONE;
      illegal_o <= 1'b0;
    end else if (!flush_i) begin
      if (push && (count == 2'd0 || pop)) begin
        data1_o   <= rs_data_i;
        data2_o   <= dec_data2;
        ALUCtrl_o <= dec_ctrl;
        illegal_o <= dec_illegal;
      end else if (pop && count == 2'd2) begin
        data1_o   <= skid_data1;
        data2_o   <= skid_data2;
        ALUCtrl_o <= skid_ctrl;
        illegal_o <= skid_illegal;
      end
    end
  end

  // Skid register: captures a push that arrives behind a stalled head.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      skid_data1   <= 32'd0;
      skid_data2   <= 32'd0;
      skid_ctrl    <= CTRL_NONE;
      skid_illegal <= 1'b0;
    end else if (!flush_i && push && !pop && count == 2'd1) begin
      skid_data1   <= rs_data_i;
      skid_data2   <= dec_data2;
      skid_ctrl    <= dec_ctrl;
      skid_illegal <= dec_illegal;
    end
  end

  // Issue counter; a pop during a flush still reached EX, so it counts.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      issue_cnt_o <= 16'd0;
    end else if (pop) begin
      issue_cnt_o <= issue_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed steps plus randomized traffic
// compared against a queue-based reference model.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        valid_in;
  logic        ready_out;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [15:0] imm;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [2:0]  alu_ctrl;
  logic        illegal;
  logic [15:0] issue_cnt;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .flush_i     (flush),
    .valid_i     (valid_in),
    .ready_o     (ready_out),
    .op_i        (op),
    .funct_i     (funct),
    .rs_data_i   (rs_data),
    .rt_data_i   (rt_data),
    .imm_i       (imm),
    .valid_o     (valid_out),
    .ready_i     (ready_in),
    .data1_o     (data1),
    .data2_o     (data2),
    .ALUCtrl_o   (alu_ctrl),
    .illegal_o   (illegal),
    .issue_cnt_o (issue_cnt)
  );

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [2:0]  ctrl;
    logic        ill;
  } entry_t;

  entry_t q[$];
  int     model_issued = 0;
  int     n_cmp = 0;
  int     n_bad = 0;

  // Reference decode written from the instruction table.
  function automatic entry_t ref_decode(logic [5:0] o, logic [5:0] f,
                                        logic [31:0] rs, logic [31:0] rt,
                                        logic [15:0] im);
    entry_t e;
    e.d1 = rs; e.d2 = rt; e.ctrl = 3'd0; e.ill = 1'b0;
    if (o == 6'h00 && f == 6'h20) e.ctrl = 3'd1;
    else if (o == 6'h00 && f == 6'h22) e.ctrl = 3'd2;
    else if (o == 6'h00 && f == 6'h24) e.ctrl = 3'd3;
    else if (o == 6'h00 && f == 6'h25) e.ctrl = 3'd4;
    else if (o == 6'h00 && f == 6'h18) e.ctrl = 3'd5;
    else if (o == 6'h08 || o == 6'h23 || o == 6'h2B) begin
      e.ctrl = 3'd1;
      e.d2   = 32'($signed(im));
    end else if (o == 6'h04) e.ctrl = 3'd2;
    else e.ill = 1'b1;
    return e;
  endfunction

  task automatic cmp(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    cmp("ready_o", 32'(ready_out), 32'(q.size() < 2));
    cmp("valid_o", 32'(valid_out), 32'(q.size() > 0));
    cmp("issue_cnt_o", 32'(issue_cnt), 32'(16'(model_issued)));
    if (q.size() > 0) begin
      cmp("data1_o", data1, q[0].d1);
      cmp("data2_o", data2, q[0].d2);
      cmp("ALUCtrl_o", 32'(alu_ctrl), 32'(q[0].ctrl));
      cmp("illegal_o", 32'(illegal), 32'(q[0].ill));
    end
  endtask

  task automatic set_in(logic v, logic [5:0] o, logic [5:0] f, logic [31:0] rs,
                        logic [31:0] rt, logic [15:0] im, logic r, logic fl);
    valid_in = v; op = o; funct = f; rs_data = rs; rt_data = rt; imm = im;
    ready_in = r; flush = fl;
  endtask

  // Random instruction biased toward the decodable cases.
  task automatic set_rand(logic v, logic r, logic fl);
    logic [5:0] o, f;
    int sel;
    sel = $urandom_range(0, 9);
    o = 6'h00; f = 6'h20;
    case (sel)
      0: f = 6'h20;
      1: f = 6'h22;
      2: f = 6'h24;
      3: f = 6'h25;
      4: f = 6'h18;
      5: o = 6'h08;
      6: o = 6'h23;
      7: o = 6'h2B;
      8: o = 6'h04;
      default: begin o = 6'($urandom); f = 6'($urandom); end
    endcase
    set_in(v, o, f, $urandom, $urandom, 16'($urandom), r, fl);
  endtask

  // One clock: advance the model with the current inputs, then sample at negedge.
  task automatic tick(bit chk);
    bit do_push, do_pop;
    entry_t e;
    do_push = valid_in && (q.size() < 2);
    do_pop  = ready_in && (q.size() > 0);
    e = ref_decode(op, funct, rs_data, rt_data, imm);
    @(posedge clk);
    if (do_pop) begin
      void'(q.pop_front());
      model_issued++;
    end
    if (flush) q.delete();
    else if (do_push) q.push_back(e);
    @(negedge clk);
    if (chk) check_model();
  endtask

  task automatic check_reset_values(string tag);
    cmp({tag, "_valid"}, 32'(valid_out), 32'd0);
    cmp({tag, "_ready"}, 32'(ready_out), 32'd1);
    cmp({tag, "_data1"}, data1, 32'd0);
    cmp({tag, "_data2"}, data2, 32'd0);
    cmp({tag, "_ctrl"}, 32'(alu_ctrl), 32'd0);
    cmp({tag, "_illegal"}, 32'(illegal), 32'd0);
    cmp({tag, "_cnt"}, 32'(issue_cnt), 32'd0);
  endtask

  logic [5:0]  d_op[4]    = '{6'h08, 6'h04, 6'h00, 6'h3F};
  logic [5:0]  d_funct[4] = '{6'h00, 6'h00, 6'h18, 6'h00};
  logic [2:0]  d_ctrl[4]  = '{3'd1, 3'd2, 3'd5, 3'd0};
  logic        d_ill[4]   = '{1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    int base;
    rst_n = 1'b0;
    set_in(1'b0, 6'h00, 6'h00, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0);
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // add rs 5 rt 7
    set_in(1'b1, 6'h00, 6'h20, 32'd5, 32'd7, 16'd0, 1'b1, 1'b0);
    tick(1);
    cmp("add_valid", 32'(valid_out), 32'd1);
    cmp("add_data1", data1, 32'd5);
    cmp("add_data2", data2, 32'd7);
    cmp("add_ctrl", 32'(alu_ctrl), 32'd1);
    valid_in = 1'b0;
    tick(1);
    cmp("add_issue_cnt", 32'(issue_cnt), 32'd1);

    // addi with negative immediate
    set_in(1'b1, 6'h08, 6'h00, 32'd10, 32'd99, 16'hFFFE, 1'b1, 1'b0);
    tick(1);
    cmp("addi_data1", data1, 32'd10);
    cmp("addi_data2", data2, 32'hFFFF_FFFE);
    cmp("addi_ctrl", 32'(alu_ctrl), 32'd1);

    // addi/beq/mul/illegal back to back
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, d_op[i], d_funct[i], 32'(i + 100), 32'(i + 200), 16'h1234, 1'b1, 1'b0);
      tick(1);
      cmp("dec_ctrl", 32'(alu_ctrl), 32'(d_ctrl[i]));
      cmp("dec_illegal", 32'(illegal), 32'(d_ill[i]));
    end
    valid_in = 1'b0;
    tick(1);

    // backpressure: sub, and, or with EX stalled
    set_in(1'b1, 6'h00, 6'h22, 32'd1, 32'd2, 16'd0, 1'b0, 1'b0);
    tick(1);
    set_in(1'b1, 6'h00, 6'h24, 32'd3, 32'd4, 16'd0, 1'b0, 1'b0);
    tick(1);
    cmp("bp_ready_low", 32'(ready_out), 32'd0);
    set_in(1'b1, 6'h00, 6'h25, 32'd5, 32'd6, 16'd0, 1'b0, 1'b0);
    tick(1);
    tick(1);
    cmp("bp_head_sub", 32'(alu_ctrl), 32'd2);
    cmp("bp_head_stable", data1, 32'd1);
    ready_in = 1'b1;
    tick(1);
    cmp("bp_head_and", 32'(alu_ctrl), 32'd3);
    cmp("bp_ready_back", 32'(ready_out), 32'd1);
    tick(1);
    cmp("bp_head_or", 32'(alu_ctrl), 32'd4);
    valid_in = 1'b0;
    tick(1);
    cmp("bp_drained", 32'(valid_out), 32'd0);

    // streaming for 20 cycles
    base = model_issued;
    for (int i = 0; i < 20; i++) begin
      set_rand(1'b1, 1'b1, 1'b0);
      tick(1);
    end
    valid_in = 1'b0;
    tick(1);
    cmp("stream_cnt", 32'(issue_cnt), 32'(16'(base + 20)));

    // flush at count 2 with a simultaneous push
    set_rand(1'b1, 1'b0, 1'b0);
    tick(1);
    set_rand(1'b1, 1'b0, 1'b0);
    tick(1);
    cmp("flush_pre_ready", 32'(ready_out), 32'd0);
    set_rand(1'b1, 1'b0, 1'b1);
    tick(1);
    cmp("flush_valid", 32'(valid_out), 32'd0);
    cmp("flush_ready", 32'(ready_out), 32'd1);
    set_rand(1'b0, 1'b1, 1'b0);
    tick(1);
    tick(1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      set_rand(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
               1'($urandom_range(0, 19) == 0));
      tick(1);
    end

    // async reset mid-stream
    set_rand(1'b1, 1'b0, 1'b0);
    tick(1);
    set_rand(1'b1, 1'b0, 1'b0);
    tick(1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    q.delete();
    model_issued = 0;
    @(negedge clk);
    rst_n = 1'b1;
    set_rand(1'b0, 1'b1, 1'b0);
    tick(1);

    // issue counter wrap
    while (model_issued < 65535) begin
      set_rand(1'b1, 1'b1, 1'b0);
      tick(0);
    end
    cmp("cnt_ffff", 32'(issue_cnt), 32'h0000_FFFF);
    valid_in = 1'b0;
    tick(1);
    cmp("cnt_wrap", 32'(issue_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
